// File: rtl/tick_mod_counter.sv
// Modulo-MOD up/down counter stepped by a clock-enable prescaler on sys_clk.
// Supports clear, saturating load, direction, one-shot stop, and tick/wrap/done status.
module tick_mod_counter #(
    parameter int unsigned     WIDTH = 32,
    parameter int unsigned     DIV   = 50_000_000,
    parameter longint unsigned MOD   = 11
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             one_shot,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             done
);

    localparam int               DIV_W    = $clog2(DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 64'd1);

    if (MOD < 2 || MOD > (64'd1 << WIDTH) || DIV < 1) begin : g_bad_params
        $error("tick_mod_counter: illegal MOD/DIV/WIDTH combination");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [WIDTH-1:0] load_sat;
    logic             at_term;

    assign load_sat = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign at_term  = up ? (count == MAX_VAL) : (count == '0);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values and the block order cannot change behaviour.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count   <= '0;
            div_cnt <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Pulses default low; only a prescaler rollover raises them.
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clr) begin
                count   <= '0;
                div_cnt <= '0;
                done    <= 1'b0;
            end else if (load) begin
                count   <= load_sat;
                div_cnt <= '0;
                done    <= 1'b0;
            end else if (en) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    tick    <= 1'b1;
                    if (one_shot && at_term) begin
                        done <= 1'b1;
                    end else if (up) begin
                        if (count == MAX_VAL) begin
                            count <= '0;
                            wrap  <= 1'b1;
                        end else begin
                            count <= count + WIDTH'(1);
                        end
                    end else begin
                        if (count == '0) begin
                            count <= MAX_VAL;
                            wrap  <= 1'b1;
                        end else begin
                            count <= count - WIDTH'(1);
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_mod_counter.sv
// Scoreboard bench: stimulus pushes expected tick events; negedge monitors pop and compare.
// Main instance DIV=4/MOD=11, second instance DIV=1/MOD=2.
module tb_tick_mod_counter;

    typedef struct {
        int          cyc;
        logic [31:0] count;
        logic        wrap;
        logic        done;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        en, up, one_shot, clr, load, en2;
    logic [31:0] load_val;
    logic [31:0] count, count2;
    logic        tick, wrap, done, tick2, wrap2, done2;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q1[$];
    exp_t q2[$];

    tick_mod_counter #(.WIDTH(32), .DIV(4), .MOD(11)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en), .up(up),
        .one_shot(one_shot), .clr(clr), .load(load), .load_val(load_val),
        .count(count), .tick(tick), .wrap(wrap), .done(done)
    );

    tick_mod_counter #(.WIDTH(32), .DIV(1), .MOD(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en2), .up(1'b1),
        .one_shot(1'b0), .clr(1'b0), .load(1'b0), .load_val(32'd0),
        .count(count2), .tick(tick2), .wrap(wrap2), .done(done2)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic push1(input int c, input logic [31:0] cnt, input logic w, input logic d);
        q1.push_back('{cyc: c, count: cnt, wrap: w, done: d});
    endtask

    task automatic push2(input int c, input logic [31:0] cnt, input logic w);
        q2.push_back('{cyc: c, count: cnt, wrap: w, done: 1'b0});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic quiesce();
        en  = 1'b0;
        clr = 1'b1;
        wait_cyc(1);
        clr = 1'b0;
    endtask

    // Monitors: every tick must match the next expected event in its queue.
    always @(negedge sys_clk) begin
        if (tick) begin
            if (q1.size() == 0) begin
                check("dut unexpected tick", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut tick cycle", cyc, e.cyc);
                check("dut count", count, e.count);
                check("dut wrap", wrap, e.wrap);
                check("dut done", done, e.done);
            end
        end
        if (tick2) begin
            if (q2.size() == 0) begin
                check("dut2 unexpected tick", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("dut2 tick cycle", cyc, e.cyc);
                check("dut2 count", count2, e.count);
                check("dut2 wrap", wrap2, e.wrap);
            end
        end
    end

    initial begin
        int t0, t1;
        sys_rst_n = 1'b0;
        en = 1'b0; up = 1'b1; one_shot = 1'b0; clr = 1'b0; load = 1'b0;
        load_val = 32'd0; en2 = 1'b0;
        wait_cyc(2);
        check("reset count", count, 0);
        check("reset tick", tick, 0);
        check("reset wrap", wrap, 0);
        check("reset done", done, 0);
        sys_rst_n = 1'b1;
        wait_cyc(1);

        // Up count: a full lap plus one step.
        en = 1'b1; up = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 12; k++) push1(t0 + 4*k, 32'(k % 11), (k == 11), 1'b0);
        wait_cyc(48);
        quiesce();
        check("clr count", count, 0);

        // Down count wraps 0 -> 10 on the first tick.
        en = 1'b1; up = 1'b0;
        t0 = cyc;
        push1(t0 + 4, 10, 1'b1, 1'b0);
        push1(t0 + 8, 9, 1'b0, 1'b0);
        push1(t0 + 12, 8, 1'b0, 1'b0);
        push1(t0 + 16, 7, 1'b0, 1'b0);
        wait_cyc(16);
        quiesce();

        // One-shot up from 8: stops at 10 and raises done on the terminal step.
        load_val = 32'd8; load = 1'b1;
        wait_cyc(1);
        load = 1'b0;
        check("load 8", count, 8);
        en = 1'b1; up = 1'b1; one_shot = 1'b1;
        t0 = cyc;
        push1(t0 + 4, 9, 1'b0, 1'b0);
        push1(t0 + 8, 10, 1'b0, 1'b0);
        for (int k = 3; k <= 5; k++) push1(t0 + 4*k, 10, 1'b0, 1'b1);
        wait_cyc(20);
        en = 1'b0;
        wait_cyc(1);
        check("one-shot held count", count, 10);
        check("one-shot done level", done, 1);
        quiesce();
        check("clr after done count", count, 0);
        check("clr clears done", done, 0);

        // One-shot down: terminal is 0, so the first tick only sets done.
        en = 1'b1; up = 1'b0;
        t0 = cyc;
        push1(t0 + 4, 0, 1'b0, 1'b1);
        wait_cyc(4);
        quiesce();
        one_shot = 1'b0; up = 1'b1;

        // Saturating load, then a load that lands on a rollover edge.
        load_val = 32'd25; load = 1'b1;
        wait_cyc(1);
        load = 1'b0;
        check("load saturates", count, 10);
        load_val = 32'd5; en = 1'b1;
        t0 = cyc;
        wait_cyc(3);
        load = 1'b1;
        wait_cyc(1);
        load = 1'b0;
        check("load on rollover count", count, 5);
        check("load on rollover tick", tick, 0);
        push1(t0 + 8, 6, 1'b0, 1'b0);
        wait_cyc(4);
        quiesce();

        // Enable dropped at div_cnt=2 for 7 cycles; resume ticks 2 cycles later.
        en = 1'b1;
        wait_cyc(2);
        en = 1'b0;
        wait_cyc(7);
        check("frozen count", count, 0);
        check("frozen tick", tick, 0);
        en = 1'b1;
        t1 = cyc;
        push1(t1 + 2, 1, 1'b0, 1'b0);
        wait_cyc(2);
        quiesce();

        // Asynchronous reset between edges at count=7.
        en = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 7; k++) push1(t0 + 4*k, 32'(k), 1'b0, 1'b0);
        wait_cyc(29);
        check("pre-reset count", count, 7);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async reset count", count, 0);
        check("async reset tick", tick, 0);
        check("async reset wrap", wrap, 0);
        check("async reset done", done, 0);
        wait_cyc(1);
        sys_rst_n = 1'b1;
        t1 = cyc;
        push1(t1 + 4, 1, 1'b0, 1'b0);
        wait_cyc(4);
        quiesce();

        // DIV=1, MOD=2: toggles every cycle, wrap on each 1 -> 0.
        en2 = 1'b1;
        t0 = cyc;
        for (int k = 1; k <= 6; k++) push2(t0 + k, 32'(k % 2), (k % 2 == 0));
        wait_cyc(6);
        en2 = 1'b0;
        wait_cyc(2);

        check("dut queue drained", q1.size(), 0);
        check("dut2 queue drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
